serial_compare_msb: RTL and testbench



---
 rtl/serial_compare_msb_pkg.sv | 24 ++
 rtl/serial_compare_msb_if.sv | 27 ++
 rtl/serial_compare_msb_cell.sv | 13 +
 rtl/serial_compare_msb.sv | 93 +++++++++
 tb/tb_serial_compare_msb.sv | 139 +++++++++++++
 5 files changed

// File: rtl/serial_compare_msb_pkg.sv
// Shared types for the MSB-first serial comparator.
// State encodings and the {lt,eq,gt} flag bundle.
package serial_compare_msb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    // Flag order reused by the ALU control for SLT/branch decode.
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } flags_t;

    localparam flags_t FLAGS_EQ = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

    function automatic flags_t mk_diff(input logic a_lt_b);
        return '{lt: a_lt_b, eq: 1'b0, gt: ~a_lt_b};
    endfunction

endpackage

// File: rtl/serial_compare_msb_if.sv
// Request/result bundle between the ALU control and the
// serial comparator.
interface serial_compare_msb_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [CW-1:0]    scanned;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, lt, eq, gt, scanned
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, lt, eq, gt, scanned
    );
endinterface

// File: rtl/serial_compare_msb_cell.sv
// One-bit compare cell; at the signed MSB the sense of
// "less than" flips because that bit carries negative weight.
module compare_msb_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb_signed,
    output logic differ,
    output logic a_lt_b
);
    assign differ = a_bit ^ b_bit;
    assign a_lt_b = is_msb_signed ? (a_bit & ~b_bit)
                                  : (~a_bit & b_bit);
endmodule

// File: rtl/serial_compare_msb.sv
// Sequential MSB-first magnitude comparator, one bit per cycle,
// stopping at the first differing bit.
module serial_compare_msb
    import serial_compare_msb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input logic              clk,
    input logic              reset_n,
    serial_compare_msb_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    scanned_q;
    flags_t           res_q;
    logic             accept;
    logic             differ;
    logic             a_lt_b;
    logic             last;

    // DONE accepts too, giving back-to-back compares.
    assign accept = bus.start && (state != SCAN);
    assign last   = (idx == '0);

    compare_msb_cell u_cell (
        .a_bit         (a_q[idx]),
        .b_bit         (b_q[idx]),
        .is_msb_signed (sgn_q && (idx == TOP)),
        .differ        (differ),
        .a_lt_b        (a_lt_b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = SCAN;
            SCAN: if (differ || last) state_nxt = DONE;
            DONE: state_nxt = bus.start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            scanned_q <= '0;
            res_q     <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sgn_q <= bus.is_signed;
            idx   <= TOP;
            cnt   <= '0;
        end else if (state == SCAN) begin
            cnt <= cnt + 1'b1;
            if (differ) begin
                res_q     <= mk_diff(a_lt_b);
                scanned_q <= cnt + 1'b1;
            end else if (last) begin
                res_q     <= FLAGS_EQ;
                scanned_q <= cnt + 1'b1;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

    assign bus.busy    = (state == SCAN);
    assign bus.done    = (state == DONE);
    assign bus.lt      = res_q.lt;
    assign bus.eq      = res_q.eq;
    assign bus.gt      = res_q.gt;
    assign bus.scanned = scanned_q;

endmodule

// File: tb/tb_serial_compare_msb.sv
// Directed bench for serial_compare_msb at WIDTH=8.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_compare_msb;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    serial_compare_msb_if #(.WIDTH(8)) bus ();

    serial_compare_msb #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_done(input string tag, output int nbusy);
        nbusy = 0;
        for (int c = 0; c < 40 && bus.done !== 1'b1; c++) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        chk({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic run(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic s,
                       input logic elt, input logic eeq,
                       input logic egt, input int escn);
        int nb;
        bus.a = a;
        bus.b = b;
        bus.is_signed = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        bus.is_signed = ~s;
        wait_done(tag, nb);
        chk({tag, ".lt"}, 32'(bus.lt), 32'(elt));
        chk({tag, ".eq"}, 32'(bus.eq), 32'(eeq));
        chk({tag, ".gt"}, 32'(bus.gt), 32'(egt));
        chk({tag, ".scanned"}, 32'(bus.scanned), 32'(escn));
        chk({tag, ".busy_cycles"}, 32'(nb), 32'(escn));
        chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int nb;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.flags", 32'({bus.lt, bus.eq, bus.gt}), 32'd0);
        chk("rst.scanned", 32'(bus.scanned), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run("msb_u",   8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run("msb_s",   8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        run("equal",   8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        run("lsb_u",   8'h04, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 8);
        run("lsb_s",   8'hFE, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        run("mid_s",   8'hF0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        run("mid_u",   8'h3C, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 5);

        // Start while busy is ignored; then start held across DONE.
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.a = 8'hFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign.busy", 32'(bus.busy), 32'd1);
        bus.a = 8'h01;
        bus.b = 8'h00;
        bus.start = 1'b1;
        wait_done("ign", nb);
        chk("ign.eq", 32'(bus.eq), 32'd1);
        chk("ign.lt_gt", 32'({bus.lt, bus.gt}), 32'd0);
        chk("ign.scanned", 32'(bus.scanned), 32'd8);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b.busy", 32'(bus.busy), 32'd1);
        wait_done("b2b", nb);
        chk("b2b.gt", 32'(bus.gt), 32'd1);
        chk("b2b.lt_eq", 32'({bus.lt, bus.eq}), 32'd0);
        chk("b2b.scanned", 32'(bus.scanned), 32'd8);
        chk("b2b.busy_cycles", 32'(nb), 32'd8);
        @(negedge clk);

        // Asynchronous abort in the third SCAN cycle.
        bus.a = 8'h10;
        bus.b = 8'h11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.done", 32'(bus.done), 32'd0);
        chk("abort.flags", 32'({bus.lt, bus.eq, bus.gt}), 32'd0);
        chk("abort.scanned", 32'(bus.scanned), 32'd0);
        @(negedge clk);
        chk("abort.no_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run("post_rst", 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
